// File: rtl/MD_pkg.sv
// Shared types and constants for the motion-update read sequencer.
// FSM state encoding is fixed because it is exported as a debug output.
package MD_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mu_seq_state_t;

  localparam int MU_RD_LATENCY = 2;
  localparam int MU_NUM_CELLS  = 8;
  localparam int MU_PID_WIDTH  = 8;

endpackage

// File: rtl/mu_cell_addr_gen.sv
// Per-cell read address walker for one position cache.
// Latches the particle count on load, then issues 0..count-1 as ready allows.
module mu_cell_addr_gen
  import MD_pkg::*;
#(
  parameter int PW = MU_PID_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          run_i,
  input  logic          ready_i,
  input  logic [PW-1:0] count_i,
  output logic          rd_en_o,
  output logic [PW-1:0] rd_addr_o,
  output logic          done_o
);

  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] addr_q, addr_d;
  logic [PW-1:0] rd_addr_q, rd_addr_d;
  logic          done_q, done_d;
  logic          rd_en_q, rd_en_d;
  logic          issue;
  logic [PW-1:0] last_addr;

  assign last_addr = count_q - PW'(1);
  assign issue     = run_i && !done_q && ready_i;

  // Next state: load resets the walk, an issue advances it by one address
  always_comb begin
    count_d   = count_q;
    addr_d    = addr_q;
    done_d    = done_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    if (load_i) begin
      count_d = count_i;
      addr_d  = '0;
      done_d  = (count_i == '0);
    end else if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = addr_q;
      addr_d    = addr_q + PW'(1);
      if (addr_q == last_addr) begin
        done_d = 1'b1;
      end
    end
  end

  // Per-cell state and registered cache read outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      count_q   <= count_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign done_o    = done_q;

endmodule

// File: rtl/mu_rd_sequencer.sv
// Motion-update read sequencer: one pass walks every home-cell cache in parallel.
// Pass ends after all cells finish and the cache read pipeline drains.
module mu_rd_sequencer
  import MD_pkg::*;
#(
  parameter int NUM_CELLS         = MU_NUM_CELLS,
  parameter int PARTICLE_ID_WIDTH = MU_PID_WIDTH,
  parameter int RD_LATENCY        = MU_RD_LATENCY
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_MU_start,
  input  logic                                   i_iter_target_reached,
  input  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] i_num_particles,
  input  logic [NUM_CELLS-1:0]                   i_MU_ready,
  output logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] o_MU_rd_addr,
  output logic [NUM_CELLS-1:0]                   o_MU_rd_en,
  output logic [NUM_CELLS-1:0]                   o_cell_done,
  output logic                                   o_MU_working,
  output logic                                   o_MU_done,
  output logic [2:0]                             o_state
);

  localparam int PW = PARTICLE_ID_WIDTH;
  localparam int DL = (RD_LATENCY < 1) ? 1 : RD_LATENCY;
  localparam int DW = (DL > 1) ? $clog2(DL) : 1;

  mu_seq_state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          load;
  logic          run;
  logic          all_done;

  assign load     = (state_q == ST_LOAD);
  assign run      = (state_q == ST_READ);
  assign all_done = &o_cell_done;

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
    mu_cell_addr_gen #(
      .PW (PW)
    ) u_gen (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .run_i     (run),
      .ready_i   (i_MU_ready[g]),
      .count_i   (i_num_particles[g*PW +: PW]),
      .rd_en_o   (o_MU_rd_en[g]),
      .rd_addr_o (o_MU_rd_addr[g*PW +: PW]),
      .done_o    (o_cell_done[g])
    );
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; drain counter only runs while in DRAIN
  always_comb begin
    state_d = state_q;
    drain_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_MU_start && !i_iter_target_reached) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_READ;
      ST_READ: begin
        if (all_done) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(DL - 1)) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    o_MU_working = 1'b0;
    o_MU_done    = 1'b0;
    o_state      = state_q;
    unique case (state_q)
      ST_LOAD, ST_READ, ST_DRAIN: o_MU_working = 1'b1;
      ST_DONE:                    o_MU_done    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mu_rd_sequencer.sv
// Directed self-checking bench for mu_rd_sequencer.
// Expected cycle offsets are counted from the cycle holding the start pulse.
module tb_mu_rd_sequencer;

  localparam int NC = 8;
  localparam int PW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_MU_start;
  logic             i_iter_target_reached;
  logic [NC*PW-1:0] i_num_particles;
  logic [NC-1:0]    i_MU_ready;
  logic [NC*PW-1:0] o_MU_rd_addr;
  logic [NC-1:0]    o_MU_rd_en;
  logic [NC-1:0]    o_cell_done;
  logic             o_MU_working;
  logic             o_MU_done;
  logic [2:0]       o_state;

  int checks = 0;
  int failures = 0;

  int st_log [300];
  logic [NC-1:0] en_log [300];
  logic [NC-1:0] cd_log [300];
  logic wk_log [300];
  logic [PW-1:0] a0_log [300];
  int rk [NC][300];
  int ra [NC][300];
  int rn [NC];
  int done_at;
  int done_n;

  int xs_k = 0;
  int np_k = 0;
  logic [NC*PW-1:0] np_new;
  logic [NC-1:0] rdy_even;
  logic [NC-1:0] rdy_odd;

  always #5 clk = ~clk;

  mu_rd_sequencer dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_MU_start            (i_MU_start),
    .i_iter_target_reached (i_iter_target_reached),
    .i_num_particles       (i_num_particles),
    .i_MU_ready            (i_MU_ready),
    .o_MU_rd_addr          (o_MU_rd_addr),
    .o_MU_rd_en            (o_MU_rd_en),
    .o_cell_done           (o_cell_done),
    .o_MU_working          (o_MU_working),
    .o_MU_done             (o_MU_done),
    .o_state               (o_state)
  );

  task automatic run_pass(input int nk);
    for (int c = 0; c < NC; c++) rn[c] = 0;
    done_at = -1;
    done_n = 0;
    i_MU_start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= nk; k++) begin
      i_MU_start = (k == xs_k);
      i_MU_ready = (k % 2 == 0) ? rdy_even : rdy_odd;
      if (k == np_k) i_num_particles = np_new;
      @(negedge clk);
      st_log[k] = int'(o_state);
      en_log[k] = o_MU_rd_en;
      cd_log[k] = o_cell_done;
      wk_log[k] = o_MU_working;
      a0_log[k] = o_MU_rd_addr[PW-1:0];
      if (o_MU_done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      for (int c = 0; c < NC; c++) begin
        if (o_MU_rd_en[c]) begin
          rk[c][rn[c]] = k;
          ra[c][rn[c]] = int'(o_MU_rd_addr[c*PW +: PW]);
          rn[c]++;
        end
      end
      @(posedge clk); #1;
    end
    i_MU_start = 1'b0;
    xs_k = 0;
    np_k = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (o_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", o_state);
    end
    checks++;
    if (o_MU_rd_en !== '0 || o_MU_rd_addr !== '0 || o_cell_done !== '0) begin
      failures++;
      $display("FAIL reset_outs got en=%h addr=%h cd=%h exp=0", o_MU_rd_en, o_MU_rd_addr, o_cell_done);
    end
    checks++;
    if (o_MU_working !== 1'b0 || o_MU_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got wk=%b dn=%b exp=0", o_MU_working, o_MU_done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int exp_st [10] = '{0, 1, 2, 2, 2, 2, 3, 3, 4, 0};
    logic [NC-1:0] exp_en [10] = '{8'h00, 8'h00, 8'h00, 8'hff, 8'hff, 8'hff, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [NC-1:0] exp_cd [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff};
    logic exp_wk [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    i_num_particles = {NC{8'd3}};
    rdy_even = '1;
    rdy_odd = '1;
    run_pass(12);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (st_log[k] !== exp_st[k]) begin
        failures++;
        $display("FAIL basic_state k=%0d got=%0d exp=%0d", k, st_log[k], exp_st[k]);
      end
      checks++;
      if (en_log[k] !== exp_en[k]) begin
        failures++;
        $display("FAIL basic_rd_en k=%0d got=%h exp=%h", k, en_log[k], exp_en[k]);
      end
      checks++;
      if (wk_log[k] !== exp_wk[k]) begin
        failures++;
        $display("FAIL basic_working k=%0d got=%b exp=%b", k, wk_log[k], exp_wk[k]);
      end
      if (k >= 2) begin
        checks++;
        if (cd_log[k] !== exp_cd[k]) begin
          failures++;
          $display("FAIL basic_cell_done k=%0d got=%h exp=%h", k, cd_log[k], exp_cd[k]);
        end
      end
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (rn[c] !== 3 || rk[c][0] !== 3 || ra[c][0] !== 0 || ra[c][1] !== 1 ||
          ra[c][2] !== 2 || rk[c][2] !== 5) begin
        failures++;
        $display("FAIL basic_reads cell=%0d got n=%0d k0=%0d a=%0d,%0d,%0d exp n=3 k0=3 a=0,1,2",
                 c, rn[c], rk[c][0], ra[c][0], ra[c][1], ra[c][2]);
      end
    end
    checks++;
    if (a0_log[7] !== 8'd2) begin
      failures++;
      $display("FAIL basic_addr_hold got=%0d exp=2", a0_log[7]);
    end
    checks++;
    if (done_at !== 8 || done_n !== 1) begin
      failures++;
      $display("FAIL basic_done got at=%0d n=%0d exp at=8 n=1", done_at, done_n);
    end
  endtask

  task automatic test_backpressure();
    int exp_k5 [4] = '{3, 5, 7, 9};
    i_num_particles = {NC{8'd2}};
    i_num_particles[5*PW +: PW] = 8'd4;
    rdy_even = '1;
    rdy_odd = 8'hdf;
    run_pass(16);
    checks++;
    if (rn[5] !== 4) begin
      failures++;
      $display("FAIL bp_cell5_count got=%0d exp=4", rn[5]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rk[5][i] !== exp_k5[i] || ra[5][i] !== i) begin
        failures++;
        $display("FAIL bp_cell5_read i=%0d got k=%0d a=%0d exp k=%0d a=%0d",
                 i, rk[5][i], ra[5][i], exp_k5[i], i);
      end
    end
    checks++;
    if (rn[0] !== 2 || rk[0][0] !== 3 || rk[0][1] !== 4 || ra[0][1] !== 1) begin
      failures++;
      $display("FAIL bp_cell0 got n=%0d k=%0d,%0d a1=%0d exp n=2 k=3,4 a1=1",
               rn[0], rk[0][0], rk[0][1], ra[0][1]);
    end
    checks++;
    if (done_at !== 12 || done_n !== 1) begin
      failures++;
      $display("FAIL bp_done got at=%0d n=%0d exp at=12 n=1", done_at, done_n);
    end
  endtask

  task automatic test_zero_max();
    int bad = 0;
    i_num_particles = {NC{8'd1}};
    i_num_particles[0 +: PW] = 8'd0;
    i_num_particles[7*PW +: PW] = 8'd255;
    rdy_even = '1;
    rdy_odd = '1;
    run_pass(265);
    checks++;
    if (cd_log[2][0] !== 1'b1 || rn[0] !== 0) begin
      failures++;
      $display("FAIL zero_cell0 got cd=%b n=%0d exp cd=1 n=0", cd_log[2][0], rn[0]);
    end
    checks++;
    if (rn[7] !== 255) begin
      failures++;
      $display("FAIL max_cell7_count got=%0d exp=255", rn[7]);
    end
    for (int i = 0; i < 255; i++) begin
      if (ra[7][i] != i || rk[7][i] != i + 3) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL max_cell7_seq got bad=%0d exp=0", bad);
    end
    checks++;
    if (done_at !== 260 || done_n !== 1) begin
      failures++;
      $display("FAIL max_done got at=%0d n=%0d exp at=260 n=1", done_at, done_n);
    end
  endtask

  task automatic test_ignored_starts();
    int bad = 0;
    i_num_particles = {NC{8'd2}};
    rdy_even = '1;
    rdy_odd = '1;
    xs_k = 3;
    run_pass(14);
    for (int k = 8; k <= 14; k++) if (st_log[k] != 0) bad++;
    checks++;
    if (done_at !== 7 || done_n !== 1 || bad !== 0) begin
      failures++;
      $display("FAIL start_in_read got at=%0d n=%0d busy=%0d exp at=7 n=1 busy=0",
               done_at, done_n, bad);
    end
    checks++;
    if (rn[3] !== 2) begin
      failures++;
      $display("FAIL start_in_read_reads got=%0d exp=2", rn[3]);
    end
    i_iter_target_reached = 1'b1;
    bad = 0;
    run_pass(8);
    for (int k = 1; k <= 8; k++) if (st_log[k] != 0 || wk_log[k] != 1'b0) bad++;
    checks++;
    if (bad !== 0 || done_n !== 0 || rn[0] !== 0) begin
      failures++;
      $display("FAIL start_target got busy=%0d n=%0d reads=%0d exp 0 0 0", bad, done_n, rn[0]);
    end
    i_iter_target_reached = 1'b0;
  endtask

  task automatic test_count_change();
    i_num_particles = {NC{8'd2}};
    np_new = {NC{8'd5}};
    np_k = 2;
    rdy_even = '1;
    rdy_odd = '1;
    run_pass(12);
    for (int c = 0; c < NC; c += 7) begin
      checks++;
      if (rn[c] !== 2) begin
        failures++;
        $display("FAIL count_change cell=%0d got=%0d exp=2", c, rn[c]);
      end
    end
    checks++;
    if (done_at !== 7) begin
      failures++;
      $display("FAIL count_change_done got=%0d exp=7", done_at);
    end
  endtask

  task automatic test_reset_mid_pass();
    int pulses = 0;
    i_num_particles = {NC{8'd50}};
    i_MU_ready = '1;
    i_MU_start = 1'b1;
    @(posedge clk); #1;
    i_MU_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (o_state !== 3'd2 || o_MU_rd_en !== 8'hff) begin
      failures++;
      $display("FAIL mid_pass_pre got st=%0d en=%h exp st=2 en=ff", o_state, o_MU_rd_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (o_MU_done) pulses++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (o_state !== 3'd0 || o_MU_rd_en !== '0 || o_MU_rd_addr !== '0 ||
        o_cell_done !== '0 || o_MU_working !== 1'b0 || pulses !== 0) begin
      failures++;
      $display("FAIL mid_pass_reset got st=%0d en=%h addr=%h cd=%h wk=%b pulses=%0d exp all 0",
               o_state, o_MU_rd_en, o_MU_rd_addr, o_cell_done, o_MU_working, pulses);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (o_state !== 3'd0 || o_MU_done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got st=%0d dn=%b exp st=0 dn=0", o_state, o_MU_done);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    i_MU_start = 1'b0;
    i_iter_target_reached = 1'b0;
    i_num_particles = '0;
    i_MU_ready = '1;
    np_new = '0;
    rdy_even = '1;
    rdy_odd = '1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_max();
    test_ignored_starts();
    test_count_change();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
